// File: rtl/scan_bus_pkg.sv
// Shared types and constants for the scan-chain bus sequencer.
//   state_t : sequencer states
//   cmd_t   : command latched from the scan chain on an accepted trigger
package scan_bus_pkg;

  localparam int unsigned ADDR_W       = 20;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BUS_ADDR_W   = ADDR_W - 2;

  // addr[18] picks group B; bus_addr[11] picks ctrl register (1) vs SRAM (0)
  localparam int unsigned GRP_SEL_BIT  = 18;
  localparam int unsigned CTRL_SEL_BIT = 11;

  localparam int unsigned ST_W         = 3;
  localparam int unsigned ST_ILLEGAL   = 0;
  localparam int unsigned ST_TIMEOUT   = 1;
  localparam int unsigned ST_OVERRUN   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    REQ   = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/scan_id_sync.sv
// Brings the asynchronous scan_id toggle into the clk domain and turns each
// level change into a one-cycle trigger.
//   clk, rst : clock and (already synchronised) active-high reset
//   scan_id  : transaction toggle from the scan domain
//   trig_c   : combinational one-cycle trigger pulse
module scan_id_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scan_id,
  output logic trig_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   primed_q;

  // Synchroniser chain has no reset so it keeps tracking scan_id while reset is
  // held; the history flop then primes to the true level and a stale scan_id
  // does not look like a toggle once reset is released.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], scan_id};
  end

  // History flop; the first cycle out of reset only primes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      hist_q   <= sync_q[SYNC_STAGES-1];
      primed_q <= 1'b1;
    end
  end

  assign trig_c = primed_q & (sync_q[SYNC_STAGES-1] ^ hist_q);

endmodule

// File: rtl/scan_bus_ctrl.sv
// Chip-side sequencer behind the scan chain: runs one bus transaction per
// scan_id toggle, routes it to group A/B by addr[18], and captures the result.
//   clk, rst                    : clock, async active-high reset
//   scan_wen/ren/addr/wdata     : scan-loaded command (static)
//   scan_id                     : transaction toggle, async to clk
//   grp_a_req, grp_b_req        : per-group request, held until ack/timeout
//   bus_we, bus_addr, bus_wdata : shared bus fields, stable during REQ
//   grp_x_ack, grp_x_rdata      : per-group completion and read data
//   scan_rdata, scan_ready      : captured result for scan read-back
//   status                      : sticky {overrun, timeout, illegal}
module scan_bus_ctrl
  import scan_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_wen,
  input  logic                  scan_ren,
  input  logic [ADDR_W-1:0]     scan_addr,
  input  logic [DATA_W-1:0]     scan_wdata,
  input  logic                  scan_id,
  output logic                  grp_a_req,
  output logic                  grp_b_req,
  output logic                  bus_we,
  output logic [BUS_ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic                  grp_a_ack,
  input  logic                  grp_b_ack,
  input  logic [DATA_W-1:0]     grp_a_rdata,
  input  logic [DATA_W-1:0]     grp_b_rdata,
  output logic [DATA_W-1:0]     scan_rdata,
  output logic                  scan_ready,
  output logic [ST_W-1:0]       status
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  // Reset: asserts asynchronously, releases on a clk edge.
  logic [1:0] rst_pipe_q;
  logic       rst_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe_q <= 2'b11;
    else     rst_pipe_q <= {rst_pipe_q[0], 1'b0};
  end

  assign rst_i = rst_pipe_q[1];

  logic trig_c;

  scan_id_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst_i),
    .scan_id (scan_id),
    .trig_c  (trig_c)
  );

  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  ren_q, ren_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  grp_a_req_d, grp_b_req_d, bus_we_d, scan_ready_d;
  logic [BUS_ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0]     bus_wdata_d, scan_rdata_d;
  logic [ST_W-1:0]       status_d;
  logic                  sel_b, ack_sel;
  logic                  unused_addr_msb;

  assign sel_b           = cmd_q.addr[GRP_SEL_BIT];
  assign ack_sel         = sel_b ? grp_b_ack : grp_a_ack;
  assign unused_addr_msb = cmd_q.addr[ADDR_W-1];

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    ren_d        = ren_q;
    cnt_d        = cnt_q;
    grp_a_req_d  = grp_a_req;
    grp_b_req_d  = grp_b_req;
    bus_we_d     = bus_we;
    bus_addr_d   = bus_addr;
    bus_wdata_d  = bus_wdata;
    scan_rdata_d = scan_rdata;
    scan_ready_d = scan_ready;
    status_d     = status;

    case (state_q)
      IDLE: begin
        if (trig_c) begin
          cmd_d.we               = scan_wen;
          cmd_d.addr             = scan_addr;
          cmd_d.wdata            = scan_wdata;
          ren_d                  = scan_ren;
          scan_ready_d           = 1'b0;
          status_d[ST_TIMEOUT]   = 1'b0;
          status_d[ST_ILLEGAL]   = 1'b0;
          state_d                = CHECK;
        end
      end
      CHECK: begin
        if (cmd_q.we == ren_q) begin
          status_d[ST_ILLEGAL] = 1'b1;
          state_d              = IDLE;
        end else begin
          bus_we_d    = cmd_q.we;
          bus_addr_d  = cmd_q.addr[BUS_ADDR_W-1:0];
          bus_wdata_d = cmd_q.wdata;
          grp_a_req_d = ~sel_b;
          grp_b_req_d = sel_b;
          cnt_d       = '0;
          // A read starts from a cleared capture so a timeout leaves it empty.
          if (!cmd_q.we) scan_rdata_d = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // Ack beats a coincident timeout.
        if (ack_sel) begin
          grp_a_req_d  = 1'b0;
          grp_b_req_d  = 1'b0;
          scan_ready_d = 1'b1;
          if (!bus_we) scan_rdata_d = sel_b ? grp_b_rdata : grp_a_rdata;
          state_d      = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          grp_a_req_d          = 1'b0;
          grp_b_req_d          = 1'b0;
          status_d[ST_TIMEOUT] = 1'b1;
          state_d              = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Triggers arriving mid-transaction are dropped but remembered.
    if (trig_c && (state_q != IDLE)) status_d[ST_OVERRUN] = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      ren_q      <= 1'b0;
      cnt_q      <= '0;
      grp_a_req  <= 1'b0;
      grp_b_req  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      scan_rdata <= '0;
      scan_ready <= 1'b0;
      status     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      ren_q      <= ren_d;
      cnt_q      <= cnt_d;
      grp_a_req  <= grp_a_req_d;
      grp_b_req  <= grp_b_req_d;
      bus_we     <= bus_we_d;
      bus_addr   <= bus_addr_d;
      bus_wdata  <= bus_wdata_d;
      scan_rdata <= scan_rdata_d;
      scan_ready <= scan_ready_d;
      status     <= status_d;
    end
  end

endmodule

// File: tb/tb_scan_bus_ctrl.sv
// Directed bench for scan_bus_ctrl: write, read, timeout, illegal, overrun and
// reset-during-request scenarios with hand-computed expectations.
module tb_scan_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_wen, scan_ren, scan_id;
  logic [19:0] scan_addr;
  logic [31:0] scan_wdata;
  logic        grp_a_req, grp_b_req, bus_we;
  logic [17:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        grp_a_ack, grp_b_ack;
  logic [31:0] grp_a_rdata, grp_b_rdata;
  logic [31:0] scan_rdata;
  logic        scan_ready;
  logic [2:0]  status;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scan_bus_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .scan_wen    (scan_wen),
    .scan_ren    (scan_ren),
    .scan_addr   (scan_addr),
    .scan_wdata  (scan_wdata),
    .scan_id     (scan_id),
    .grp_a_req   (grp_a_req),
    .grp_b_req   (grp_b_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .grp_a_ack   (grp_a_ack),
    .grp_b_ack   (grp_b_ack),
    .grp_a_rdata (grp_a_rdata),
    .grp_b_rdata (grp_b_rdata),
    .scan_rdata  (scan_rdata),
    .scan_ready  (scan_ready),
    .status      (status)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic w, input logic r, input logic [19:0] a, input logic [31:0] d);
    scan_wen   = w;
    scan_ren   = r;
    scan_addr  = a;
    scan_wdata = d;
  endtask

  initial begin
    int  n;
    logic seen;

    rst = 1'b1; scan_id = 1'b0;
    load(1'b0, 1'b0, 20'h0, 32'h0);
    grp_a_ack = 1'b0; grp_b_ack = 1'b0;
    grp_a_rdata = 32'h0; grp_b_rdata = 32'h0;

    // Reset state
    cyc(4);
    chk("rst_a_req",  32'(grp_a_req), 32'h0);
    chk("rst_b_req",  32'(grp_b_req), 32'h0);
    chk("rst_we",     32'(bus_we), 32'h0);
    chk("rst_addr",   32'(bus_addr), 32'h0);
    chk("rst_wdata",  bus_wdata, 32'h0);
    chk("rst_rdata",  scan_rdata, 32'h0);
    chk("rst_ready",  32'(scan_ready), 32'h0);
    chk("rst_status", 32'(status), 32'h0);
    rst = 1'b0;
    cyc(6);

    // Write to group A; req rises on the 4th edge after the toggle
    load(1'b1, 1'b0, 20'h00001, 32'h87654321);
    scan_id = 1'b1;
    cyc(3);
    chk("wr_no_req_early", 32'(grp_a_req), 32'h0);
    cyc(1);
    chk("wr_a_req",  32'(grp_a_req), 32'h1);
    chk("wr_b_req",  32'(grp_b_req), 32'h0);
    chk("wr_we",     32'(bus_we), 32'h1);
    chk("wr_addr",   32'(bus_addr), 32'h00001);
    chk("wr_wdata",  bus_wdata, 32'h87654321);
    load(1'b0, 1'b1, 20'hFFFFF, 32'hDEADDEAD);
    cyc(3);
    chk("wr_addr_stable", 32'(bus_addr), 32'h00001);
    grp_a_ack = 1'b1;
    cyc(1);
    grp_a_ack = 1'b0;
    chk("wr_req_drop", 32'(grp_a_req), 32'h0);
    chk("wr_ready",    32'(scan_ready), 32'h1);
    chk("wr_rdata_unchanged", scan_rdata, 32'h0);
    chk("wr_status",   32'(status), 32'h0);

    // Read from group B, ctrl register
    load(1'b0, 1'b1, 20'h40800, 32'h0);
    scan_id = 1'b0;
    cyc(4);
    chk("rd_b_req",  32'(grp_b_req), 32'h1);
    chk("rd_a_req",  32'(grp_a_req), 32'h0);
    chk("rd_we",     32'(bus_we), 32'h0);
    chk("rd_addr",   32'(bus_addr), 32'h00800);
    chk("rd_ready_cleared", 32'(scan_ready), 32'h0);
    grp_b_rdata = 32'hF1F2F3FF; grp_a_rdata = 32'h11111111;
    grp_b_ack = 1'b1;
    cyc(1);
    grp_b_ack = 1'b0;
    chk("rd_req_drop", 32'(grp_b_req), 32'h0);
    chk("rd_rdata",    scan_rdata, 32'hF1F2F3FF);
    chk("rd_ready",    32'(scan_ready), 32'h1);

    // Timeout: read group B, no ack; req high exactly 32 cycles
    load(1'b0, 1'b1, 20'h40007, 32'h0);
    scan_id = 1'b1;
    cyc(4);
    n = 0;
    while (grp_b_req && n < 100) begin
      n++;
      cyc(1);
    end
    chk("to_req_cycles", 32'(n), 32'd32);
    chk("to_status",     32'(status), 32'h2);
    chk("to_ready",      32'(scan_ready), 32'h0);
    chk("to_rdata",      scan_rdata, 32'h0);

    // Illegal: both enables set, no request ever issued
    load(1'b1, 1'b1, 20'h00005, 32'h55555555);
    scan_id = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (grp_a_req || grp_b_req) seen = 1'b1;
    end
    chk("ill_no_req", 32'(seen), 32'h0);
    chk("ill_status", 32'(status), 32'h1);

    // Valid write afterwards clears the illegal bit
    load(1'b1, 1'b0, 20'h00010, 32'h12345678);
    scan_id = 1'b1;
    cyc(4);
    chk("ill_clr_a_req",  32'(grp_a_req), 32'h1);
    chk("ill_clr_status", 32'(status), 32'h0);
    grp_a_ack = 1'b1;
    cyc(1);
    grp_a_ack = 1'b0;
    chk("ill_clr_ready", 32'(scan_ready), 32'h1);

    // Overrun: second toggle 10 cycles into a group-B read
    load(1'b0, 1'b1, 20'h40004, 32'h0);
    scan_id = 1'b0;
    cyc(4);
    chk("ov_b_req", 32'(grp_b_req), 32'h1);
    cyc(6);
    scan_id = 1'b1;
    cyc(4);
    chk("ov_status", 32'(status), 32'h4);
    chk("ov_b_req_held", 32'(grp_b_req), 32'h1);
    grp_a_ack = 1'b1; grp_a_rdata = 32'h22222222;
    cyc(1);
    grp_a_ack = 1'b0;
    cyc(1);
    chk("ov_wrong_ack_ignored", 32'(grp_b_req), 32'h1);
    grp_b_ack = 1'b1; grp_b_rdata = 32'hCAFEF00D;
    cyc(1);
    grp_b_ack = 1'b0;
    chk("ov_rdata", scan_rdata, 32'hCAFEF00D);
    chk("ov_ready", 32'(scan_ready), 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (grp_a_req || grp_b_req) seen = 1'b1;
    end
    chk("ov_single_txn", 32'(seen), 32'h0);
    chk("ov_sticky", 32'(status), 32'h4);

    // Reset during REQ with scan_id left high
    load(1'b1, 1'b0, 20'h00002, 32'hA5A5A5A5);
    scan_id = 1'b0;
    cyc(4);
    chk("rr_a_req", 32'(grp_a_req), 32'h1);
    chk("rr_overrun_kept", 32'(status), 32'h4);
    scan_id = 1'b1;
    cyc(4);
    rst = 1'b1;
    #1;
    chk("rr_req_drop_async", 32'(grp_a_req), 32'h0);
    chk("rr_status_clr",     32'(status), 32'h0);
    cyc(3);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (grp_a_req || grp_b_req) seen = 1'b1;
    end
    chk("rr_no_stale_trig", 32'(seen), 32'h0);
    load(1'b0, 1'b1, 20'h00003, 32'h0);
    scan_id = 1'b0;
    cyc(4);
    chk("rr_new_a_req", 32'(grp_a_req), 32'h1);
    chk("rr_new_addr",  32'(bus_addr), 32'h00003);
    grp_a_rdata = 32'h0BADBEEF;
    grp_a_ack = 1'b1;
    cyc(1);
    grp_a_ack = 1'b0;
    chk("rr_new_rdata", scan_rdata, 32'h0BADBEEF);
    chk("rr_new_ready", 32'(scan_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
